// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : HI/LO multiply/divide unit (fixed 5/10-cycle latency).
//            Build macro MDU_MADD_EN enables MADD/MADDU accumulate ops.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
`endif
    localparam logic [3:0] c_MUL_CYC  = 4'd5;
    localparam logic [3:0] c_DIV_CYC  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [63:0] r_res;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_sgn_m;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_last;

`ifdef MDU_MADD_EN
    logic        w_is_madd;
    assign w_is_madd = (Op == c_OP_MADD) || (Op == c_OP_MADDU);
    assign w_is_mul  = (Op == c_OP_MULT) || (Op == c_OP_MULTU) || w_is_madd;
    assign w_sgn_m   = (Op == c_OP_MULT) || (Op == c_OP_MADD);
`else
    assign w_is_mul  = (Op == c_OP_MULT) || (Op == c_OP_MULTU);
    assign w_sgn_m   = (Op == c_OP_MULT);
`endif
    assign w_is_div  = (Op == c_OP_DIV) || (Op == c_OP_DIVU);

    // Low 64 bits of a 64x64 product of extended operands serve both signednesses
    assign w_prod = {{32{w_sgn_m & A[31]}}, A} * {{32{w_sgn_m & B[31]}}, B};

`ifdef MDU_MADD_EN
    assign w_mul_res = w_is_madd ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
    assign w_mul_res = w_prod;
`endif

    // Sign-magnitude divide: 0x80000000 / -1 falls out as 0x80000000 rem 0
    assign w_neg_a = (Op == c_OP_DIV) & A[31];
    assign w_neg_b = (Op == c_OP_DIV) & B[31];
    assign w_abs_a = w_neg_a ? (32'd0 - A) : A;
    assign w_abs_b = w_neg_b ? (32'd0 - B) : B;
    assign w_dvs   = (B == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uq    = w_abs_a / w_dvs;
    assign w_ur    = w_abs_a % w_dvs;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    assign w_last  = (r_cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (Start && w_is_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_res <= 64'd0;
            r_dz  <= 1'b0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (Start && w_is_mul) begin
                r_res <= w_mul_res;
                r_dz  <= 1'b0;
                r_cnt <= c_MUL_CYC;
            end else if (Start && w_is_div) begin
                r_res <= {w_r, w_q};
                r_dz  <= (B == 32'd0);
                r_cnt <= c_DIV_CYC;
            end else if (Start && (Op == c_OP_MTHI)) begin
                r_hi <= A;
            end else if (Start && (Op == c_OP_MTLO)) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if (w_last && !r_dz) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end
    end

    assign Busy = (r_state != S_IDLE);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          vectors;
    int          miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, let the unit run to completion, then compare latency and HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input bit noise);
        int                 lat;
        int                 cnt;
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [31:0]        eh;
        logic [31:0]        el;
        eh  = m_hi;
        el  = m_lo;
        lat = 0;
        p   = 64'd0;
        case (op)
            4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {eh, el} = p; lat = 5; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; lat = 5; end
            4'd3: begin
                lat = 10;
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            4'd4: begin
                lat = 10;
                if (b != 32'd0) begin
                    el = a / b;
                    eh = a % b;
                end
            end
            4'd5: eh = a;
            4'd6: el = a;
`ifdef MDU_MADD_EN
            4'd7: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = {m_hi, m_lo} + p;
                lat = 5;
            end
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                {eh, el} = {m_hi, m_lo} + p;
                lat = 5;
            end
`endif
            default: ;
        endcase
        @(negedge clk);
        A = a; B = b; Op = op; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        A = $urandom; B = $urandom;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (noise) begin
                Start = 1'b1;
                Op = (cnt == 1) ? 4'd3 : (cnt == 2) ? 4'd6 : 4'($urandom_range(0, 15));
            end
            A = $urandom; B = $urandom;
            @(negedge clk);
            Start = 1'b0;
        end
        check({tag, " busy_cycles"}, 64'(cnt), 64'(lat));
        check({tag, " HI"}, {32'd0, HI}, {32'd0, eh});
        check({tag, " LO"}, {32'd0, LO}, {32'd0, el});
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        vectors = 0; miscompares = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        rst_n = 1'b0; Start = 1'b1; Op = 4'd5; A = 32'hDEADBEEF; B = 32'd0;

        // Reset with Start held high: Start must be ignored
        repeat (3) @(negedge clk);
        check("reset Busy", {63'd0, Busy}, 64'd0);
        check("reset HI", {32'd0, HI}, 64'd0);
        check("reset LO", {32'd0, LO}, 64'd0);
        rst_n = 1'b1; Start = 1'b0;

        run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        check("mult_neg const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_max const", {HI, LO}, 64'hFFFFFFFE_00000001);
        run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 1'b0);
        check("divu_zero const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf const", {HI, LO}, 64'h00000000_80000000);
        run_op("mult_busy_ign", 4'd1, 32'h00012345, 32'h00006789, 1'b1);
        run_op("undef_op", 4'd15, 32'h11111111, 32'h22222222, 1'b0);

        // MTHI then MTLO on back-to-back edges
        @(negedge clk);
        Op = 4'd5; A = 32'h12345678; Start = 1'b1;
        @(negedge clk);
        check("mthi Busy", {63'd0, Busy}, 64'd0);
        Op = 4'd6; A = 32'h9ABCDEF0;
        @(negedge clk);
        Start = 1'b0;
        check("mtlo Busy", {63'd0, Busy}, 64'd0);
        check("mthi_mtlo HILO", {HI, LO}, 64'h12345678_9ABCDEF0);
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

        run_op("set_hi", 4'd5, 32'h0, 32'h0, 1'b0);
        run_op("set_lo", 4'd6, 32'hFFFFFFFF, 32'h0, 1'b0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("maddu const", {HI, LO}, 64'h00000001_00000000);
`else
        check("maddu const", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset during the third busy cycle aborts the multiply
        @(negedge clk);
        Op = 4'd1; A = 32'h0000FFFF; B = 32'h0000FFFF; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("abort busy1", {63'd0, Busy}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort Busy", {63'd0, Busy}, 64'd0);
        check("abort HILO", {HI, LO}, 64'd0);
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("post_reset", 4'd2, 32'd6, 32'd7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-002 clk  input  1  Rising-edge clock; all state updates occur on this edge.
REQ-003 rst_n  input  1  Synchronous reset, active low.
REQ-004 A  input  32  Operand A: dividend, multiplicand, or source for MTHI/MTLO.
REQ-005 B  input  32  Operand B: divisor or multiplier.
REQ-006 Op  input  4  Operation code:
- 0000 none; 0001 MULT; 0010 MULTU; 0011 DIV; 0100 DIVU; 0101 MTHI; 0110 MTLO.
- 0111 MADD and 1000 MADDU under MDU_MADD_EN only.
- All other codes are treated as none.
REQ-007 Start  input  1  Qualifies Op for one cycle.
REQ-008 Busy  output  1  High while a multiply or divide is in progress.
REQ-009 HI  output  32  HI register, driven directly from a flop.
REQ-010 LO  output  32  LO register, driven directly from a flop.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, MUL, DIV.
REQ-012 In IDLE, Start=1 with a multiply-class Op (MULT/MULTU, plus MADD/MADDU when enabled) SHALL perform all of the following at that edge:
- go to MUL;
- latch the 64-bit result;
- load the cycle counter with 5.
REQ-013 In IDLE, Start=1 with DIV/DIVU SHALL perform all of the following at that edge:
- go to DIV;
- latch quotient and remainder;
- latch a div-by-zero flag;
- load the cycle counter with 10.
REQ-014 Busy SHALL equal (state != IDLE); it rises one cycle after the Start edge.
REQ-015 The counter SHALL decrement each cycle in MUL or DIV. On the edge where it reaches 0, the unit SHALL write HI/LO and return to IDLE in that same edge.
- MUL: Busy is high for exactly 5 cycles.
- DIV: Busy is high for exactly 10 cycles.
- New HI/LO are visible in the cycle Busy falls.
REQ-016 MULT SHALL produce a signed 32x32 to 64 product; MULTU SHALL produce an unsigned product. HI = bits[63:32], LO = bits[31:0].
REQ-017 DIV SHALL produce a signed quotient truncated toward zero, with the remainder taking the sign of the dividend: LO = quotient, HI = remainder. DIVU SHALL perform the same operation unsigned.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0x00000000, with no trap.
REQ-019 Divide by zero SHALL still hold Busy for 10 cycles, and HI/LO SHALL remain unchanged.
REQ-020 MTHI/MTLO with Start=1 in IDLE SHALL write A into HI or LO at that edge. Busy SHALL stay 0 and the state SHALL stay IDLE.
REQ-021 Start while Busy=1 SHALL be ignored for every Op: the in-flight operation, counter, and HI/LO SHALL be unaffected.
REQ-022 A and B SHALL be sampled only at the Start edge; changes to them during Busy SHALL have no effect.
REQ-023 Start=1 with Op none or an undefined code SHALL cause no state change.
REQ-024 Start=0 SHALL never change any state.

Reset
REQ-025 When rst_n=0 at a clock edge, the unit SHALL set state = IDLE, counter = 0, Busy = 0, HI = 0x00000000, LO = 0x00000000.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no HI/LO write. Start is ignored in any cycle where rst_n=0.

Configuration
REQ-027 The macro MDU_MADD_EN SHALL control support for multiply-accumulate.
- Defined: MADD SHALL compute {HI,LO} + signed(A*B) and MADDU SHALL compute {HI,LO} + unsigned(A*B). The sum wraps modulo 2^64, uses the HI/LO values at the Start edge, and has 5-cycle latency as in MUL.
- Undefined: codes 0111 and 1000 SHALL be treated as none, and no accumulate logic SHALL exist.

Verification
REQ-028 Reset, then MULT A=0xFFFFFFFE (-2), B=0x00000003 -> Busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA when Busy falls.
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
REQ-030 Directed divide cases, each with Busy high 10 cycles:
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> HI/LO unchanged.
REQ-031 Busy and reset cases:
- MULT in flight, then Start DIV and MTLO during Busy -> both ignored; only the MULT result is written.
- Separately, rst_n=0 in the third Busy cycle -> Busy=0, HI=LO=0 the next cycle.
REQ-032 MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0, Busy never 1.
REQ-033 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=0x00000001, LO=0x00000000.
- Without MDU_MADD_EN, the same stimulus -> no change, Busy stays 0.
